// File: rtl/jtgng_pxlser_if.sv
// Bundle of the tile-fetch / ROM / pixel signals around jtgng_pxlser.
// The serializer itself keeps flat ports so a parent can wire it straight
// into its ROM arbiter and per-layer delay line. Environments that drive or
// observe it as a unit use this bundle.
//   master : tile source + ROM side (drives start/code/pal/flips/vrow, rom_ok/rom_data)
//   slave  : serializer side (drives rom_addr/rom_cs, pxl, underrun)
interface jtgng_pxlser_if #(
    parameter int PALW = 4,
    parameter int AW   = 13
);
    logic            cen;
    logic            start;
    logic [9:0]      code;
    logic [PALW-1:0] pal;
    logic            hflip;
    logic            vflip;
    logic [2:0]      vrow;
    logic [AW-1:0]   rom_addr;
    logic            rom_cs;
    logic            rom_ok;
    logic [15:0]     rom_data;
    logic [PALW+1:0] pxl;
    logic            underrun;

    modport master (
        output cen, start, code, pal, hflip, vflip, vrow, rom_ok, rom_data,
        input  rom_addr, rom_cs, pxl, underrun
    );

    modport slave (
        input  cen, start, code, pal, hflip, vflip, vrow, rom_ok, rom_data,
        output rom_addr, rom_cs, pxl, underrun
    );
endinterface

// File: rtl/jtgng_pxlser.sv
// Tile pixel serializer: fetches one 8-pixel, 2-plane tile row from ROM per
// tile slot and shifts it out one pixel per cen.
// One-tile pipeline: the row fetched after start N is held in a next-buffer
// and only reaches the shifter on start N+1.
// Ports:
//   rst, clk            async active-high reset, single clock
//   cen                 pixel clock enable
//   start               tile boundary strobe (qualified by cen)
//   code/pal/hflip/vflip/vrow  attributes of the next tile to fetch
//   rom_addr, rom_cs    ROM request ({code, row}); cs high only while waiting
//   rom_ok, rom_data    ROM answer; [15:8] plane 1, [7:0] plane 0, bit 7 leftmost
//   pxl                 {pal, plane1, plane0} of the current pixel
//   underrun            one-clock pulse when a tile boundary found no data
module jtgng_pxlser #(
    parameter int PALW = 4,
    parameter int AW   = 13
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            cen,
    input  logic            start,
    input  logic [9:0]      code,
    input  logic [PALW-1:0] pal,
    input  logic            hflip,
    input  logic            vflip,
    input  logic [2:0]      vrow,
    output logic [AW-1:0]   rom_addr,
    output logic            rom_cs,
    input  logic            rom_ok,
    input  logic [15:0]     rom_data,
    output logic [PALW+1:0] pxl,
    output logic            underrun
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]      st_q, st_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [PALW-1:0] fpal_q, fpal_d;       // attributes of the fetch in flight
    logic            fhflip_q, fhflip_d;
    logic [15:0]     nbuf_q, nbuf_d;       // next-buffer
    logic [PALW-1:0] npal_q, npal_d;
    logic            nhflip_q, nhflip_d;
    logic            bvalid_q, bvalid_d;
    logic [7:0]      sh1_q, sh1_d, sh0_q, sh0_d;
    logic [PALW-1:0] shpal_q, shpal_d;
    logic            shflip_q, shflip_d;
    logic [PALW+1:0] pxl_q, pxl_d;
    logic            undr_q, undr_d;

    logic strobe;
    logic head1, head0;

    assign strobe = start & cen;
    // The pixel leaving the shifter sits at the end it shifts towards.
    assign head1  = shflip_q ? sh1_q[0] : sh1_q[7];
    assign head0  = shflip_q ? sh0_q[0] : sh0_q[7];

    always_comb begin
        st_d     = st_q;
        addr_d   = addr_q;
        fpal_d   = fpal_q;
        fhflip_d = fhflip_q;
        nbuf_d   = nbuf_q;
        npal_d   = npal_q;
        nhflip_d = nhflip_q;
        bvalid_d = bvalid_q;
        sh1_d    = sh1_q;
        sh0_d    = sh0_q;
        shpal_d  = shpal_q;
        shflip_d = shflip_q;
        pxl_d    = pxl_q;
        undr_d   = 1'b0;

        // A tile boundary on the same edge drops any data arriving for the
        // aborted fetch, so capture only without strobe.
        if (st_q == ST_REQ && rom_ok && !strobe) begin
            nbuf_d   = rom_data;
            npal_d   = fpal_q;
            nhflip_d = fhflip_q;
            bvalid_d = 1'b1;
            st_d     = ST_HOLD;
        end

        if (strobe) begin
            st_d     = ST_REQ;
            addr_d   = AW'({code, vrow ^ {3{vflip}}});
            fpal_d   = pal;
            fhflip_d = hflip;
            bvalid_d = 1'b0;
            if (bvalid_q) begin
                sh1_d    = nbuf_q[15:8];
                sh0_d    = nbuf_q[7:0];
                shpal_d  = npal_q;
                shflip_d = nhflip_q;
            end else begin
                sh1_d    = 8'h00;
                sh0_d    = 8'h00;
                shpal_d  = '0;
                shflip_d = 1'b0;
                undr_d   = 1'b1;
            end
        end else if (cen) begin
            // Zeros shift in, so a long tile slot runs out transparent.
            if (shflip_q) begin
                sh1_d = sh1_q >> 1;
                sh0_d = sh0_q >> 1;
            end else begin
                sh1_d = sh1_q << 1;
                sh0_d = sh0_q << 1;
            end
        end

        if (cen) pxl_d = {shpal_q, head1, head0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= ST_IDLE;
            addr_q   <= '0;
            fpal_q   <= '0;
            fhflip_q <= 1'b0;
            nbuf_q   <= 16'h0000;
            npal_q   <= '0;
            nhflip_q <= 1'b0;
            bvalid_q <= 1'b0;
            sh1_q    <= 8'h00;
            sh0_q    <= 8'h00;
            shpal_q  <= '0;
            shflip_q <= 1'b0;
            pxl_q    <= '0;
            undr_q   <= 1'b0;
        end else begin
            st_q     <= st_d;
            addr_q   <= addr_d;
            fpal_q   <= fpal_d;
            fhflip_q <= fhflip_d;
            nbuf_q   <= nbuf_d;
            npal_q   <= npal_d;
            nhflip_q <= nhflip_d;
            bvalid_q <= bvalid_d;
            sh1_q    <= sh1_d;
            sh0_q    <= sh0_d;
            shpal_q  <= shpal_d;
            shflip_q <= shflip_d;
            pxl_q    <= pxl_d;
            undr_q   <= undr_d;
        end
    end

    // Decoded from state so reset drops the request without waiting a clock.
    assign rom_cs   = (st_q == ST_REQ);
    assign rom_addr = addr_q;
    assign pxl      = pxl_q;
    assign underrun = undr_q;
endmodule

// File: tb/tb_jtgng_pxlser.sv
module tb_jtgng_pxlser;
    localparam int PALW = 4;
    localparam int AW   = 13;

    logic clk;
    logic rst;
    jtgng_pxlser_if #(.PALW(PALW), .AW(AW)) bus ();

    jtgng_pxlser #(.PALW(PALW), .AW(AW)) dut (
        .rst      (rst),
        .clk      (clk),
        .cen      (bus.cen),
        .start    (bus.start),
        .code     (bus.code),
        .pal      (bus.pal),
        .hflip    (bus.hflip),
        .vflip    (bus.vflip),
        .vrow     (bus.vrow),
        .rom_addr (bus.rom_addr),
        .rom_cs   (bus.rom_cs),
        .rom_ok   (bus.rom_ok),
        .rom_data (bus.rom_data),
        .pxl      (bus.pxl),
        .underrun (bus.underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [PALW+1:0] exp_q[$];
    logic [PALW+1:0] last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference pixel k of a tile row: bit 7 leftmost unless flipped; past
    // eight pixels the row is transparent but keeps its palette.
    function automatic logic [PALW+1:0] ref_px(input logic [15:0] d, input logic [PALW-1:0] p,
                                               input logic hf, input int k);
        int idx;
        if (k > 7) return {p, 2'b00};
        idx = hf ? k : 7 - k;
        return {p, d[8+idx], d[idx]};
    endfunction

    task automatic push_tile(input logic [15:0] d, input logic [PALW-1:0] p,
                             input logic hf, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(ref_px(d, p, hf, k));
    endtask

    task automatic pop_chk(input string tag);
        logic [PALW+1:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_qempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(bus.pxl), 32'(e));
            last = e;
        end
    endtask

    task automatic set_tile(input logic [9:0] c, input logic [PALW-1:0] p,
                            input logic hf, input logic vf, input logic [2:0] r);
        bus.code = c; bus.pal = p; bus.hflip = hf; bus.vflip = vf; bus.vrow = r;
    endtask

    initial begin
        rst = 1'b1;
        bus.cen = 1'b1; bus.start = 1'b0; bus.rom_ok = 1'b0; bus.rom_data = 16'h0000;
        set_tile(10'h0, '0, 1'b0, 1'b0, 3'd0);
        last = '0;
        tick(); tick();
        chk("rst_cs", 32'(bus.rom_cs), 0);
        chk("rst_addr", 32'(bus.rom_addr), 0);
        chk("rst_pxl", 32'(bus.pxl), 0);
        chk("rst_undr", 32'(bus.underrun), 0);
        rst = 1'b0;
        tick();

        // First tile: address, request, underrun from empty buffer
        set_tile(10'h155, 4'd5, 1'b0, 1'b0, 3'd3);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t1_addr", 32'(bus.rom_addr), 32'h0AAB);
        chk("t1_cs", 32'(bus.rom_cs), 1);
        chk("t1_undr", 32'(bus.underrun), 1);
        bus.rom_ok = 1'b1; bus.rom_data = 16'hF00F;
        push_tile(16'hF00F, 4'd5, 1'b0, 8);
        tick();
        bus.rom_ok = 1'b0;
        chk("t1_undr_pulse", 32'(bus.underrun), 0);
        chk("t1_cs_hold", 32'(bus.rom_cs), 0);
        tick(); tick(); tick();

        // Second start: tile 1 moves to shifter, tile 2 fetch (hflip)
        set_tile(10'h001, 4'd5, 1'b1, 1'b0, 3'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t2_undr", 32'(bus.underrun), 0);
        chk("t2_cs", 32'(bus.rom_cs), 1);
        chk("t2_addr", 32'(bus.rom_addr), 32'h0008);
        for (int i = 0; i < 8; i++) begin
            tick();
            pop_chk("t1_px");
            if (i == 2) begin
                // cen low: pixels freeze while the fetch still completes
                bus.cen = 1'b0; bus.rom_ok = 1'b1; bus.rom_data = 16'hF00F;
                push_tile(16'hF00F, 4'd5, 1'b1, 9);
                tick();
                bus.rom_ok = 1'b0;
                chk("cen0_cs", 32'(bus.rom_cs), 0);
                chk("cen0_pxl_a", 32'(bus.pxl), 32'(last));
                tick();
                chk("cen0_pxl_b", 32'(bus.pxl), 32'(last));
                bus.cen = 1'b1;
            end
        end

        // Third start: vflip address, tile 2 out with hflip, nine cens
        set_tile(10'h3FF, 4'd0, 1'b0, 1'b1, 3'd2);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t3_addr", 32'(bus.rom_addr), 32'h1FFD);
        chk("t3_undr", 32'(bus.underrun), 0);
        for (int i = 0; i < 9; i++) begin
            tick();
            pop_chk("t2_px");
        end
        chk("t3_cs_wait", 32'(bus.rom_cs), 1);

        // Fourth start with fetch 3 never answered: underrun, zeros
        set_tile(10'h0F0, 4'd3, 1'b0, 1'b0, 3'd7);
        push_tile(16'h0000, 4'd0, 1'b0, 8);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t4_undr", 32'(bus.underrun), 1);
        chk("t4_cs", 32'(bus.rom_cs), 1);
        chk("t4_addr", 32'(bus.rom_addr), 32'h0787);
        for (int i = 0; i < 8; i++) begin
            tick();
            pop_chk("t3_px");
        end
        chk("pre_rst_cs", 32'(bus.rom_cs), 1);

        // Reset in the middle of a pending request
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cs", 32'(bus.rom_cs), 0);
        chk("mid_rst_pxl", 32'(bus.pxl), 0);
        chk("mid_rst_addr", 32'(bus.rom_addr), 0);
        bus.rom_ok = 1'b1; bus.rom_data = 16'hFFFF;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("post_rst_cs", 32'(bus.rom_cs), 0);
        chk("post_rst_pxl", 32'(bus.pxl), 0);
        bus.rom_ok = 1'b0;
        set_tile(10'h002, 4'd1, 1'b0, 1'b0, 3'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("post_rst_undr", 32'(bus.underrun), 1);
        chk("post_rst_req", 32'(bus.rom_cs), 1);
        chk("q_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/jtgng_pxlser.md
JTGNG_PXLSER -- requirements
Module: jtgng_pxlser

Interface
REQ-001 Parameter: PALW, default 4, palette attribute width in bits.
REQ-002 Parameter: AW, default 13, ROM address width; SHALL equal 10+3.
REQ-003 Port: rst  input  1  asynchronous active-high reset.
REQ-004 Port: clk  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-005 Port: cen  input  1  pixel clock enable.
REQ-006 Port: start  input  1  tile-boundary strobe, qualified by cen.
REQ-007 Port: code  input  10  tile code for the next fetch.
REQ-008 Port: pal  input  PALW  palette attribute for the next fetch.
REQ-009 Port: hflip  input  1  horizontal flip for the next fetch.
REQ-010 Port: vflip  input  1  vertical flip for the next fetch.
REQ-011 Port: vrow  input  3  pixel row within the tile.
REQ-012 Port: rom_addr  output  AW  ROM word address.
REQ-013 Port: rom_cs  output  1  ROM request.
REQ-014 Port: rom_ok  input  1  ROM data valid; qualifies rom_data.
REQ-015 Port: rom_data  input  16  [15:8] = plane 1, [7:0] = plane 0; bit 7 of each byte is the leftmost pixel.
REQ-016 Port: pxl  output  PALW+2  {pal, plane1, plane0} for the current pixel; feeds the per-layer delay line.
REQ-017 Port: underrun  output  1  one-clock pulse when a tile load finds no fetched data.

Function
REQ-018 Fetch FSM SHALL have the states IDLE, REQ and HOLD.
REQ-019 In any state, start & cen SHALL latch code/pal/hflip/vflip, set rom_addr = {code, vrow ^ {3{vflip}}}, and enter REQ on the same edge.
REQ-020 In REQ, rom_cs SHALL be 1; at the first clock with rom_ok=1, the FSM SHALL capture rom_data and the latched pal/hflip into the next-buffer, set buf_valid, and enter HOLD.
REQ-021 rom_cs SHALL be 0 in IDLE and HOLD; rom_ok outside REQ SHALL be ignored.
REQ-022 start & cen while in REQ SHALL abort the pending fetch, discard any rom_ok on that same edge, and reissue with the new address; rom_cs SHALL stay high.
REQ-023 On start & cen, the shifter SHALL load the next-buffer if buf_valid=1, and buf_valid SHALL clear on that edge.
REQ-024 If buf_valid=0 at start & cen, the shifter SHALL load 16'h0000 with pal=0, and underrun SHALL pulse for one clk.
REQ-025 When both apply on one edge, the buffer transfer (REQ-023) SHALL take precedence over the new fetch capture.
REQ-026 On each cen without start, the shifter SHALL advance one pixel: left shift when hflip=0, right shift when hflip=1.
REQ-027 On each cen, pxl SHALL register {pal_sh, head1, head0}, where head = bit 7 (hflip=0) or bit 0 (hflip=1) of each plane; latency is one cen from shifter load to pixel 0 at pxl.
REQ-028 Tile N fetched after start N SHALL appear on pxl after start N+1 (one-tile pipeline).
REQ-029 If more than 8 cens elapse between starts, the shifter SHALL shift in zeros, so the output is transparent (pixel value 0).
REQ-030 With cen=0, the shifter and pxl SHALL hold; the fetch FSM SHALL still advance on rom_ok.

Reset
REQ-031 While rst=1: FSM = IDLE, rom_cs=0, rom_addr=0, buf_valid=0, shifter=0, pxl=0, underrun=0.
REQ-032 Reset asserted mid-fetch SHALL drop rom_cs on the same edge; the first start after reset SHALL produce underrun.

Structure
REQ-033 No shared package SHALL be used; FSM state encoding SHALL be local localparams.
REQ-034 The block SHALL be one module with no sub-modules; the downstream delay alignment SHALL be instantiated by the parent.

Verification
REQ-035 Scenario: reset, then start with code=10'h155, vrow=3, vflip=0 -> rom_addr=13'h0AAB, rom_cs=1; underrun pulses once.
REQ-036 Scenario: rom_data=16'hF00F, pal=5, hflip=0, then a second start -> eight pxl values after the second start are 0x16,0x16,0x16,0x16,0x15,0x15,0x15,0x15.
REQ-037 Scenario: same data with hflip=1 -> 0x15 ×4 then 0x16 ×4.
REQ-038 Scenario: vflip=1, vrow=2 -> rom_addr low bits = 3'b101.
REQ-039 Scenario: rom_ok withheld past the next start -> all-zero pixels, underrun pulse, rom_cs stays high with the new address.
REQ-040 Scenario: rst asserted during REQ -> rom_cs=0 and pxl=0 immediately; rom_ok after reset ignored.
